mult_share: RTL

- Owns the single 32x32->64 unsigned multiplier shared by the DSP waveform blocks (triangle, sine, envelope and so on).
- Serves the responder side of the mult_a / mult_b / mult_p interface those blocks initiate.
- Arbitrates among N client blocks round-robin and accepts one operand pair per cycle.
- Returns each product with fixed 2-cycle latency. Clients can therefore present operands in one state and read the product two states later.

---
 rtl/mult_share_if.sv | 18 +
 rtl/mult_share.sv | 110 +++++++++++
 2 files changed

// File: rtl/mult_share_if.sv
// Request/grant/product bundle between the DSP waveform clients and the
// shared multiplier; clients use the master view, the multiplier the slave view.
interface mult_share_if #(
  parameter int N_CLIENTS = 4,
  parameter int WIDTH     = 32
);
  logic [N_CLIENTS-1:0]       req;
  logic [N_CLIENTS*WIDTH-1:0] a;
  logic [N_CLIENTS*WIDTH-1:0] b;
  logic [N_CLIENTS-1:0]       gnt;
  logic [2*WIDTH-1:0]         p;
  logic [N_CLIENTS-1:0]       p_valid;

  modport master (output req, output a, output b,
                  input gnt, input p, input p_valid);
  modport slave  (input req, input a, input b,
                  output gnt, output p, output p_valid);
endinterface

// File: rtl/mult_share.sv
// Shared WIDTHxWIDTH unsigned multiplier: round-robin grant among N_CLIENTS,
// one operand pair per clock, product and one-hot tag returned two cycles later.
module mult_share #(
  parameter int N_CLIENTS = 4,
  parameter int WIDTH     = 32
) (
  input logic          clk,
  input logic          rst_n,
  mult_share_if.slave  bus
);
  localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int PW    = 2 * WIDTH;

  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     rr_ptr_d;
  logic [PTR_W-1:0]     gnt_idx_s;
  logic                 gnt_any_s;
  logic [N_CLIENTS-1:0] gnt_s;
  logic [WIDTH-1:0]     a_sel_s;
  logic [WIDTH-1:0]     b_sel_s;
  logic [WIDTH-1:0]     a_s1_q;
  logic [WIDTH-1:0]     b_s1_q;
  logic [N_CLIENTS-1:0] tag_s1_q;
  logic                 vld_s1_q;
  logic [PW-1:0]        prod_s;
  logic [PW-1:0]        p_q;
  logic [N_CLIENTS-1:0] p_valid_q;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CLIENTS) begin
      s = s - N_CLIENTS;
    end else begin
      s = s;
    end
    return PTR_W'(s);
  endfunction

  // Round-robin search from rr_ptr; grant is forced low while reset is held
  always_comb begin
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (!gnt_any_s && bus.req[wrap_idx(rr_ptr_q, i)]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = wrap_idx(rr_ptr_q, i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
    if (gnt_any_s && rst_n) begin
      gnt_s = N_CLIENTS'(1) << gnt_idx_s;
    end else begin
      gnt_s = '0;
    end
    rr_ptr_d = wrap_idx(gnt_idx_s, 1);
  end

  // Operand mux driven by the one-hot grant
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (gnt_s[i]) begin
        a_sel_s = bus.a[i*WIDTH +: WIDTH];
        b_sel_s = bus.b[i*WIDTH +: WIDTH];
      end else begin
        a_sel_s = a_sel_s;
      end
    end
  end

  assign prod_s = PW'(a_s1_q) * PW'(b_s1_q);

  // Pointer, operand stage and product stage; p holds until the next product lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      a_s1_q    <= '0;
      b_s1_q    <= '0;
      tag_s1_q  <= '0;
      vld_s1_q  <= 1'b0;
      p_q       <= '0;
      p_valid_q <= '0;
    end else begin
      if (gnt_any_s) begin
        rr_ptr_q <= rr_ptr_d;
        a_s1_q   <= a_sel_s;
        b_s1_q   <= b_sel_s;
        tag_s1_q <= gnt_s;
        vld_s1_q <= 1'b1;
      end else begin
        tag_s1_q <= '0;
        vld_s1_q <= 1'b0;
      end
      if (vld_s1_q) begin
        p_q       <= prod_s;
        p_valid_q <= tag_s1_q;
      end else begin
        p_valid_q <= '0;
      end
    end
  end

  assign bus.gnt     = gnt_s;
  assign bus.p       = p_q;
  assign bus.p_valid = p_valid_q;

endmodule
